// File: rtl/register_file_param.sv
// Two async-read / one-write register file with link-register destination and a
// post-reset zeroing sweep. Optional write-through forwarding under RF_BYPASS_EN.
module register_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              RegWre,
   input  logic [1:0]        RegDst,
   input  logic              DBDataSrc,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] dataFromALU,
   input  logic [DATA_W-1:0] dataFromRW,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2,
   output logic              ready
);

   // state    | meaning
   // ST_CLEAR | sweeping zeros into registers 1..DEPTH-1, reads forced to 0, writes dropped
   // ST_RUN   | normal operation, writes committed
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W-1:0] IDX_LINK = ADDR_W'(LINK_REG);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
   logic                ready_q, ready_d;

   // No reset on the array so it can map onto RAM; the sweep zeroes it instead.
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   wr_idx;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_commit;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   rd1_val, rd2_val;

   always_comb begin
      wr_idx = rt;
      unique case (RegDst)
         2'b00:   wr_idx = rt;
         2'b01:   wr_idx = rd;
         2'b10:   wr_idx = IDX_LINK;
         default: wr_idx = rt;
      endcase
      wr_data   = DBDataSrc ? dataFromRW : dataFromALU;
      wr_commit = RST_n && (state_q == ST_RUN) && RegWre &&
                  (RegDst != 2'b11) && (wr_idx != '0);
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      mem_we    = 1'b0;
      mem_waddr = wr_idx;
      mem_wdata = wr_data;
      unique case (state_q)
         ST_CLEAR: begin
            mem_we    = RST_n;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
            clr_idx_d = clr_idx_q + IDX_ONE;
            if (clr_idx_q == IDX_LAST) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            mem_we = wr_commit;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= IDX_ONE;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      rd1_val = (rs == '0) ? '0 : mem_q[rs];
      rd2_val = (rt == '0) ? '0 : mem_q[rt];
`ifdef RF_BYPASS_EN
      if (wr_commit && (rs == wr_idx)) rd1_val = wr_data;
      if (wr_commit && (rt == wr_idx)) rd2_val = wr_data;
`endif
      Data1 = (state_q == ST_CLEAR) ? '0 : rd1_val;
      Data2 = (state_q == ST_CLEAR) ? '0 : rd2_val;
   end

   assign ready = ready_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed testbench for register_file_param: reset sweep, destination modes,
// register 0, mid-run and mid-sweep reset, back-to-back writes.
module tb_register_file_param;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        RegWre;
   logic [1:0]  RegDst;
   logic        DBDataSrc;
   logic [4:0]  rs, rt, rd;
   logic [31:0] dataFromALU, dataFromRW;
   logic [31:0] Data1, Data2;
   logic        ready;

   int vectors = 0;
   int miscompares = 0;

   register_file_param dut (
      .CLK(CLK), .RST_n(RST_n), .RegWre(RegWre), .RegDst(RegDst),
      .DBDataSrc(DBDataSrc), .rs(rs), .rt(rt), .rd(rd),
      .dataFromALU(dataFromALU), .dataFromRW(dataFromRW),
      .Data1(Data1), .Data2(Data2), .ready(ready)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
      RegWre = 1'b1; RegDst = 2'b01; rd = idx; DBDataSrc = 1'b0; dataFromALU = val;
      step();
      RegWre = 1'b0;
   endtask

   // Release reset and walk the sweep, checking ready rises exactly after edge 31.
   task automatic sweep_check(input string tag);
      RST_n = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         step();
         vectors++;
         if (ready !== (e == 31)) begin
            miscompares++;
            $display("FAIL %s ready edge %0d: got %b want %b", tag, e, ready, (e == 31));
         end
      end
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      step(); step();
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 0", ready);
      end
      rs = 5'd5; rt = 5'd31;
      RST_n = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         step();
         vectors++;
         if (ready !== (e == 31)) begin
            miscompares++;
            $display("FAIL reset_sweep_ready edge %0d: got %b want %b", e, ready, (e == 31));
         end
         vectors++;
         if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_sweep_data edge %0d: got %h/%h want 0/0", e, Data1, Data2);
         end
      end
      step();
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_holds: got %b want 1", ready);
      end
   endtask

   // Stale contents must be hidden while clearing, even before the sweep reaches them.
   task automatic test_clear_masks();
      RegWre = 1'b1; RegDst = 2'b00; rt = 5'd5; DBDataSrc = 1'b0; dataFromALU = 32'hDEAD_BEEF;
      step();
      RegWre = 1'b0; rs = 5'd5;
      #1;
      vectors++;
      if (Data1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL rt_dest_write: got %h want deadbeef", Data1);
      end
      RST_n = 1'b0;
      step();
      vectors++;
      if (ready !== 1'b0 || Data1 !== 32'h0) begin
         miscompares++;
         $display("FAIL clear_mask_reset: got ready=%b d1=%h want 0/0", ready, Data1);
      end
      RST_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         vectors++;
         if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
            miscompares++;
            $display("FAIL clear_mask edge %0d: got %h/%h want 0/0", e, Data1, Data2);
         end
      end
      for (int e = 5; e <= 31; e++) step();
      vectors++;
      if (ready !== 1'b1 || Data1 !== 32'h0) begin
         miscompares++;
         $display("FAIL clear_mask_done: got ready=%b d1=%h want 1/0", ready, Data1);
      end
   endtask

   task automatic test_write_rd();
      rs = 5'd3; rt = 5'd4;
      RegWre = 1'b1; RegDst = 2'b01; rd = 5'd3; DBDataSrc = 1'b0;
      dataFromALU = 32'h1234_5678; dataFromRW = 32'hCAFE_0000;
      #1;
      vectors++;
`ifdef RF_BYPASS_EN
      if (Data1 !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL rd_same_cycle: got %h want 12345678", Data1);
      end
`else
      if (Data1 !== 32'h0) begin
         miscompares++;
         $display("FAIL rd_same_cycle: got %h want 00000000", Data1);
      end
`endif
      step();
      RegWre = 1'b0;
      #1;
      vectors++;
      if (Data1 !== 32'h1234_5678 || Data2 !== 32'h0) begin
         miscompares++;
         $display("FAIL rd_after: got %h/%h want 12345678/0", Data1, Data2);
      end
   endtask

   task automatic test_link();
      RegWre = 1'b1; RegDst = 2'b10; rd = 5'd3; rt = 5'd4; DBDataSrc = 1'b1;
      dataFromRW = 32'h0040_0004; dataFromALU = 32'h9999_9999;
      step();
      RegWre = 1'b0; rs = 5'd31;
      #1;
      vectors++;
      if (Data1 !== 32'h0040_0004) begin
         miscompares++;
         $display("FAIL link_write: got %h want 00400004", Data1);
      end
      rs = 5'd3;
      #1;
      vectors++;
      if (Data1 !== 32'h1234_5678 || Data2 !== 32'h0) begin
         miscompares++;
         $display("FAIL link_only: got %h/%h want 12345678/0", Data1, Data2);
      end
      RegWre = 1'b1; RegDst = 2'b11; rd = 5'd3; rt = 5'd31;
      dataFromALU = 32'h5555_5555; dataFromRW = 32'h6666_6666;
      step();
      RegWre = 1'b0;
      #1;
      vectors++;
      if (Data1 !== 32'h1234_5678 || Data2 !== 32'h0040_0004) begin
         miscompares++;
         $display("FAIL nowrite_dst11: got %h/%h want 12345678/00400004", Data1, Data2);
      end
      rt = 5'd4;
      #1;
      vectors++;
      if (Data2 !== 32'h0) begin
         miscompares++;
         $display("FAIL nowrite_dst11_rt: got %h want 0", Data2);
      end
   endtask

   task automatic test_reg_zero();
      rt = 5'd0; rs = 5'd0; RegWre = 1'b1; RegDst = 2'b00; DBDataSrc = 1'b0;
      dataFromALU = 32'hFFFF_FFFF;
      #1;
      vectors++;
      if (Data2 !== 32'h0 || Data1 !== 32'h0) begin
         miscompares++;
         $display("FAIL zero_same_cycle: got %h/%h want 0/0", Data1, Data2);
      end
      step();
      RegWre = 1'b0;
      #1;
      vectors++;
      if (Data2 !== 32'h0 || Data1 !== 32'h0) begin
         miscompares++;
         $display("FAIL zero_after: got %h/%h want 0/0", Data1, Data2);
      end
   endtask

   task automatic test_back_to_back();
      RegWre = 1'b1; RegDst = 2'b01; rd = 5'd10; DBDataSrc = 1'b0; dataFromALU = 32'h1111_1111;
      step();
      rd = 5'd11; dataFromALU = 32'h2222_2222; rs = 5'd10; rt = 5'd11;
      #1;
      vectors++;
`ifdef RF_BYPASS_EN
      if (Data1 !== 32'h1111_1111 || Data2 !== 32'h2222_2222) begin
         miscompares++;
         $display("FAIL b2b_mid: got %h/%h want 11111111/22222222", Data1, Data2);
      end
`else
      if (Data1 !== 32'h1111_1111 || Data2 !== 32'h0) begin
         miscompares++;
         $display("FAIL b2b_mid: got %h/%h want 11111111/0", Data1, Data2);
      end
`endif
      step();
      RegWre = 1'b0; rs = 5'd11;
      #1;
      vectors++;
      if (Data1 !== 32'h2222_2222 || Data2 !== 32'h2222_2222) begin
         miscompares++;
         $display("FAIL b2b_same_idx: got %h/%h want 22222222/22222222", Data1, Data2);
      end
   endtask

   task automatic test_reset_midrun();
      write_reg(5'd7, 32'hA5A5_A5A5);
      rs = 5'd7; rt = 5'd9;
      #1;
      vectors++;
      if (Data1 !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL midrun_pre: got %h want a5a5a5a5", Data1);
      end
      RST_n = 1'b0;
      step();
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_ready_drop: got %b want 0", ready);
      end
      RST_n = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         if (e == 10) begin
            RegWre = 1'b1; RegDst = 2'b01; rd = 5'd9; DBDataSrc = 1'b0;
            dataFromALU = 32'h7777_7777;
         end
         step();
         RegWre = 1'b0;
         vectors++;
         if (ready !== (e == 31)) begin
            miscompares++;
            $display("FAIL midrun_sweep_ready edge %0d: got %b want %b", e, ready, (e == 31));
         end
      end
      vectors++;
      if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
         miscompares++;
         $display("FAIL midrun_cleared: got %h/%h want 0/0", Data1, Data2);
      end
   endtask

   task automatic test_reset_midsweep();
      RST_n = 1'b0;
      step();
      RST_n = 1'b1;
      for (int e = 1; e <= 14; e++) step();
      RST_n = 1'b0;
      step();
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midsweep_reset: got %b want 0", ready);
      end
      sweep_check("midsweep_restart");
   endtask

   initial begin
      RST_n = 1'b0; RegWre = 1'b0; RegDst = 2'b00; DBDataSrc = 1'b0;
      rs = '0; rt = '0; rd = '0; dataFromALU = '0; dataFromRW = '0;
      test_reset();
      test_clear_masks();
      test_write_rd();
      test_link();
      test_reg_zero();
      test_back_to_back();
      test_reset_midrun();
      test_reset_midsweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
